// File: rtl/ov7670_sccb_config.sv
// OV7670 register configuration sequencer.
// Walks an external {sub_addr, value} table and emits one 3-phase SCCB write
// per entry. Two entry values are reserved: 16'hFFF0 inserts a pause of
// DELAY_CYCLES clocks (used after the COM7 soft reset), and 16'hFFFF ends the
// table. When the end marker is reached, done rises and stays high.
module ov7670_sccb_config #(
  parameter int         CLK_FREQ_HZ  = 50000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter int         GAP_QUARTERS = 4,
  parameter int         DELAY_CYCLES = 50000,
  parameter int         ADDR_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe,
  output logic              busy,
  output logic              done
);

  // One SIOC period is four quarters. Each quarter is at least one clock.
  localparam int QUARTER_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QUARTER     = (QUARTER_RAW < 1) ? 1 : QUARTER_RAW;
  localparam int QCNT_W      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int GAP_Q       = (GAP_QUARTERS < 1) ? 1 : GAP_QUARTERS;
  localparam int PH_MAX      = (GAP_Q > 4) ? GAP_Q : 4;
  localparam int PH_W        = $clog2(PH_MAX);
  localparam int DLY_N       = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
  localparam int DLY_W       = (DLY_N > 1) ? $clog2(DLY_N) : 1;

  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(QUARTER - 1);
  localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(GAP_Q - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DLY_N - 1);

  localparam logic [15:0] ENT_END   = 16'hFFFF;
  localparam logic [15:0] ENT_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [QCNT_W-1:0] qcnt_q, qcnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [4:0]        bit_q, bit_d;
  logic [26:0]       shift_q, shift_d;
  logic [DLY_W-1:0]  dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic              sioc_q, sioc_d;
  logic              sda_q, sda_d;
  logic              oe_q, oe_d;
  logic              qtr_end;

  // Next-state, counters and the bus levels that go with the next state.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dcnt_d  = dcnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pend_d  = pend_q;
    qtr_end = (qcnt_q == QCNT_LAST);

    // The quarter counter only advances while the bus is being clocked.
    if (state_q == S_START || state_q == S_BITS ||
        state_q == S_STOP  || state_q == S_GAP) begin
      qcnt_d = qtr_end ? '0 : qcnt_q + QCNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (start || pend_q) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        qcnt_d = '0;
        ph_d   = '0;
        bit_d  = '0;
        dcnt_d = '0;
        if (rom_data == ENT_END) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rom_data == ENT_DELAY) begin
          state_d = S_DELAY;
        end else begin
          // ACK / don't-care slots carry 0; the line is released there anyway.
          shift_d = {DEVICE_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
          state_d = S_START;
        end
      end
      S_START: begin
        if (qtr_end) begin
          if (ph_q == PH_W'(1)) begin
            ph_d    = '0;
            state_d = S_BITS;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_BITS: begin
        if (qtr_end) begin
          if (ph_q == PH_W'(3)) begin
            ph_d = '0;
            if (bit_q == 5'd26) begin
              state_d = S_STOP;
            end else begin
              bit_d   = bit_q + 5'd1;
              shift_d = {shift_q[25:0], 1'b0};
            end
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_STOP: begin
        if (qtr_end) begin
          if (ph_q == PH_W'(2)) begin
            ph_d    = '0;
            state_d = S_GAP;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_GAP: begin
        if (qtr_end) begin
          if (ph_q == GAP_LAST) begin
            ph_d    = '0;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (dcnt_q == DLY_LAST) begin
          dcnt_d  = '0;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          dcnt_d = dcnt_q + DLY_W'(1);
        end
      end
      S_DONE: begin
        // A start landing here is held and taken on the next clock in IDLE.
        pend_d  = start;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus levels are derived from where the FSM will be, then registered.
    sioc_d = 1'b1;
    sda_d  = 1'b1;
    oe_d   = 1'b1;
    case (state_d)
      S_START: begin
        sioc_d = (ph_d == '0);
        sda_d  = 1'b0;
      end
      S_BITS: begin
        sioc_d = ph_d[1];
        oe_d   = !(bit_d == 5'd8 || bit_d == 5'd17 || bit_d == 5'd26);
        sda_d  = oe_d ? shift_d[26] : 1'b1;
      end
      S_STOP: begin
        sioc_d = (ph_d != '0);
        sda_d  = (ph_d == PH_W'(2));
      end
      default: begin
        sioc_d = 1'b1;
        sda_d  = 1'b1;
        oe_d   = 1'b1;
      end
    endcase
  end

  // Control state, counters and registered bus/status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      dcnt_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      sioc_q  <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      dcnt_q  <= dcnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      sioc_q  <= sioc_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
    end
  end

  // Write shift register; always reloaded in DECODE before use.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign rom_addr = addr_q;
  assign sioc     = sioc_q;
  assign siod_out = sda_q;
  assign siod_oe  = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: a table-driven ROM, a bus decoder that turns
// SIOC/SIOD back into {id, sub, value} writes, and a reference model that
// predicts the write list and the busy/done timeline from the table contents.
module tb_ov7670_sccb_config;

  localparam int CLK_HZ     = 400;
  localparam int SCCB_HZ    = 100;
  localparam int GAPQ       = 4;
  localparam int DLY        = 20;
  localparam int AW         = 8;
  localparam int Q          = CLK_HZ / (4 * SCCB_HZ);
  localparam int WRITE_CLKS = (113 + GAPQ) * Q;
  localparam int INF        = 1 << 30;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          sioc, siod_out, siod_oe, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] rom [256];

  typedef struct {
    int         idx;
    logic [7:0] sub;
    logic [7:0] val;
    int         min_gap;
  } exp_t;

  exp_t        expq[$];
  logic [23:0] dec_log[$];

  // Model of the status timeline
  bit m_active = 1'b0;
  int m_acc    = 0;
  int m_T      = INF;

  // Decoder state
  bit          in_frame = 1'b0;
  int          nbits = 0, oelow = 0, viol = 0, nwrites = 0, last_stop = 0;
  logic [26:0] shr = '0;
  bit          saw_wrap = 1'b0;

  ov7670_sccb_config #(
    .CLK_FREQ_HZ (CLK_HZ),
    .SCCB_FREQ_HZ(SCCB_HZ),
    .DEVICE_ID   (8'h42),
    .GAP_QUARTERS(GAPQ),
    .DELAY_CYCLES(DLY),
    .ADDR_W      (AW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Clocks from start acceptance until done, from the table alone.
  function automatic int run_len();
    int sum = 0;
    int a   = 0;
    for (int k = 0; k < 256; k++) begin
      if (rom[a] == 16'hFFFF) return sum + 2;
      if (rom[a] == 16'hFFF0) sum += 2 + DLY;
      else sum += 2 + WRITE_CLKS;
      a = (a + 1) % 256;
    end
    return INF;
  endfunction

  // Expected write list in table order, wrapping if no end marker.
  task automatic build_expect(input int max_writes);
    int   a   = 0;
    int   gap = 0;
    exp_t e;
    expq.delete();
    dec_log.delete();
    for (int k = 0; k < 100000 && expq.size() < max_writes; k++) begin
      if (rom[a % 256] == 16'hFFFF) break;
      if (rom[a % 256] == 16'hFFF0) begin
        gap = DLY;
      end else begin
        e.idx     = a % 256;
        e.sub     = rom[a % 256][15:8];
        e.val     = rom[a % 256][7:0];
        e.min_gap = gap;
        expq.push_back(e);
        gap = 0;
      end
      a++;
    end
  endtask

  task automatic fill_end();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    m_acc    = cyc;
    m_T      = run_len();
    m_active = 1'b1;
  endtask

  // Wait for done; optionally pulse start at random while busy.
  task automatic wait_done(input int budget, input bit poke);
    int n = 0;
    int d;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
      d = cyc - m_acc;
      if (poke && d > 2 && d < m_T - 4 && $urandom_range(0, 99) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_before_timeout", done, 1);
    repeat (6) @(negedge clock);
    chk("all_writes_seen", expq.size(), 0);
  endtask

  // Compare process: bus decoding, write checks and busy/done timeline.
  initial begin
    logic sda;
    logic prev_scl, prev_sda, prev_done;
    logic [AW-1:0] prev_addr;
    int   d;
    exp_t e;
    prev_scl = 1'b1; prev_sda = 1'b1; prev_done = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clock);
      sda = siod_oe ? siod_out : 1'b1;
      if (reset) begin
        in_frame  = 1'b0;
        prev_scl  = sioc;
        prev_sda  = sda;
        prev_done = done;
        prev_addr = rom_addr;
        continue;
      end
      d = cyc - m_acc;
      if (m_active && (d < m_T - 2 || d > m_T + 2)) begin
        chk("busy", busy, (d < m_T));
        chk("done", done, (d >= m_T));
      end
      if (done && !prev_done) begin
        if (m_active) begin
          chk("done_rise_time", (d >= m_T - 2 && d <= m_T + 2), 1);
          chk("busy_falls_with_done", busy, 0);
        end else begin
          chk("done_unexpected", done, 0);
        end
      end
      if (prev_addr == AW'(255) && rom_addr == '0) saw_wrap = 1'b1;

      if (prev_scl && sioc && prev_sda && !sda) begin
        if (in_frame) viol++;
        in_frame = 1'b1;
        nbits    = 0;
        oelow    = 0;
        shr      = '0;
        if (expq.size() > 0) begin
          chk("start_rom_addr", rom_addr, expq[0].idx);
          if (expq[0].min_gap > 0)
            chk("delay_idle_gap", ((cyc - last_stop) >= expq[0].min_gap), 1);
        end
      end else if (prev_scl && sioc && !prev_sda && sda) begin
        if (!in_frame) begin
          viol++;
        end else begin
          chk("bit_count", nbits, 27);
          chk("oe_low_clocks", oelow, 12 * Q);
          dec_log.push_back({shr[26:19], shr[17:10], shr[8:1]});
          if (expq.size() == 0) begin
            chk("extra_write", expq.size(), 1);
          end else begin
            e = expq.pop_front();
            chk("write_id", shr[26:19], 8'h42);
            chk("write_sub", shr[17:10], e.sub);
            chk("write_val", shr[8:1], e.val);
          end
          nwrites++;
        end
        in_frame  = 1'b0;
        last_stop = cyc;
      end
      if (in_frame && !prev_scl && sioc && nbits < 27) begin
        shr = {shr[25:0], sda};
        nbits++;
      end
      if (in_frame && !siod_oe) oelow++;
      prev_scl  = sioc;
      prev_sda  = sda;
      prev_done = done;
      prev_addr = rom_addr;
    end
  end

  // Stimulus
  initial begin
    int          len, base, n;
    logic [7:0]  rs, rv;
    logic [15:0] w;
    reset = 1'b1;
    start = 1'b0;
    fill_end();
    repeat (3) @(negedge clock);
    chk("reset_sioc", sioc, 1);
    chk("reset_siod_out", siod_out, 1);
    chk("reset_siod_oe", siod_oe, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rom_addr", rom_addr, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Two plain writes
    fill_end();
    rom[0] = 16'h1280; rom[1] = 16'h1204;
    chk("model_run_len_literal", run_len(), 240);
    build_expect(1000);
    pulse_start();
    wait_done(1000, 1'b0);
    chk("writes_A", dec_log.size(), 2);
    if (dec_log.size() >= 2) begin
      chk("write1_literal", dec_log[0], 24'h421280);
      chk("write2_literal", dec_log[1], 24'h421204);
    end
    chk("protocol_A", viol, 0);

    // Inline delay entry, with start pokes while busy
    fill_end();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1100;
    build_expect(1000);
    pulse_start();
    wait_done(1000, 1'b1);
    chk("writes_B", dec_log.size(), 2);
    if (dec_log.size() >= 2) chk("write2_B_literal", dec_log[1], 24'h421100);
    chk("protocol_B", viol, 0);

    // Random tables
    for (int t = 0; t < 4; t++) begin
      fill_end();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        rs = 8'($urandom_range(0, 254));
        rv = 8'($urandom);
        w  = {rs, rv};
        rom[i] = ($urandom_range(0, 4) == 0) ? 16'hFFF0 : w;
      end
      build_expect(1000);
      pulse_start();
      wait_done(len * (WRITE_CLKS + DLY + 4) + 50, 1'b1);
      chk("protocol_rand", viol, 0);
    end

    // Reset during bit 12 of the first write, then restart
    fill_end();
    rom[0] = 16'h1280; rom[1] = 16'h1204;
    build_expect(1000);
    pulse_start();
    n = 0;
    while (!(in_frame && nbits == 11 && !sioc) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("reached_bit12", (in_frame && nbits == 11), 1);
    #2;
    reset = 1'b1;
    #1;
    m_active = 1'b0;
    expq.delete();
    chk("midreset_sioc", sioc, 1);
    chk("midreset_siod_out", siod_out, 1);
    chk("midreset_siod_oe", siod_oe, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_rom_addr", rom_addr, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    build_expect(1000);
    pulse_start();
    chk("restart_rom_addr", rom_addr, 0);
    wait_done(1000, 1'b1);
    chk("writes_restart", dec_log.size(), 2);
    chk("protocol_restart", viol, 0);

    // No end marker: address wraps and writes repeat
    for (int i = 0; i < 256; i++) begin
      rs = 8'($urandom_range(0, 254));
      rv = 8'($urandom);
      rom[i] = {rs, rv};
    end
    build_expect(259);
    saw_wrap = 1'b0;
    base     = nwrites;
    pulse_start();
    n = 0;
    while (nwrites < base + 259 && n < 259 * (WRITE_CLKS + 2) + 500) begin
      @(negedge clock);
      n++;
      if (n > 2 && $urandom_range(0, 499) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk("wrap_write_count", nwrites - base, 259);
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_done_low", done, 0);
    chk("wrap_busy_high", busy, 1);
    chk("wrap_queue_empty", expq.size(), 0);
    chk("protocol_wrap", viol, 0);
    #2;
    reset    = 1'b1;
    #1;
    m_active = 1'b0;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
